// File: rtl/bounce_emulator.sv
// bounce_emulator: turns a clean level into a contact-bounce burst.
// Fixed or LFSR-randomised glitch trains, then a settled hold.
module bounce_emulator #(
    parameter int          MIN_GAP    = 4,
    parameter int          GAP_W      = 3,
    parameter int          BOUNCE_MAX = 3,
    parameter int          SETTLE_CYC = 16,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clean_in,
    input  logic enable,
    input  logic rand_en,
    output logic bouncy_out,
    output logic busy,
    output logic done
);

    localparam int SEG_MAX = MIN_GAP - 1 + (1 << GAP_W) - 1;
    localparam int SEG_W   = (SEG_MAX < 2) ? 1 : $clog2(SEG_MAX + 1);
    localparam int SET_W   = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);

    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [3:0]  BMAX     = 4'(BOUNCE_MAX);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BOUNCE = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;

    logic [1:0]       state;
    logic             level;
    logic             target;
    logic [SEG_W-1:0] seg_cnt;
    logic [SEG_W-1:0] gap_q;
    logic [4:0]       tog_left;
    logic [SET_W-1:0] settle_cnt;
    logic [15:0]      lfsr;

    logic [15:0]      lfsr_nxt;
    logic [3:0]       k_sel;
    logic [4:0]       tog_init;
    logic [SEG_W-1:0] gap_m1;

    // Next LFSR value and the event parameters offered at IDLE->BOUNCE.
    always_comb begin
        lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        k_sel    = BMAX;
        gap_m1   = SEG_W'(MIN_GAP - 1);
        if (rand_en) begin
            k_sel  = (lfsr[7:4] > BMAX) ? BMAX : lfsr[7:4];
            gap_m1 = gap_m1 + SEG_W'(lfsr[GAP_W-1:0]);
        end
        tog_init = {k_sel, 1'b0};
    end

    assign busy = (state != IDLE);

    // Event FSM, bypass path and LFSR stepping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            level      <= 1'b0;
            target     <= 1'b0;
            seg_cnt    <= '0;
            gap_q      <= '0;
            tog_left   <= '0;
            settle_cnt <= '0;
            lfsr       <= SEED_EFF;
            bouncy_out <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (enable) begin
                lfsr <= lfsr_nxt;
            end
            if (!enable) begin
                state      <= IDLE;
                bouncy_out <= clean_in;
                level      <= clean_in;
            end else begin
                case (state)
                    IDLE: begin
                        if (clean_in != level) begin
                            target     <= clean_in;
                            bouncy_out <= clean_in;
                            seg_cnt    <= gap_m1;
                            gap_q      <= gap_m1;
                            tog_left   <= tog_init;
                            state      <= BOUNCE;
                        end else begin
                            bouncy_out <= level;
                        end
                    end
                    BOUNCE: begin
                        if (seg_cnt != '0) begin
                            seg_cnt <= seg_cnt - SEG_W'(1);
                        end else if (tog_left != 5'd0) begin
                            bouncy_out <= ~bouncy_out;
                            tog_left   <= tog_left - 5'd1;
                            seg_cnt    <= gap_q;
                        end else begin
                            bouncy_out <= target;
                            settle_cnt <= SET_W'(SETTLE_CYC - 1);
                            state      <= SETTLE;
                        end
                    end
                    SETTLE: begin
                        bouncy_out <= target;
                        if (settle_cnt == '0) begin
                            level <= target;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            settle_cnt <= settle_cnt - SET_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bounce_emulator.sv
// tb_bounce_emulator: directed scoreboard bench for bounce_emulator.
// Expected traces come from the event timing formulas and an LFSR model.
module tb_bounce_emulator;

    logic clk;
    logic rst_n;
    logic clean_in;
    logic enable;
    logic rand_en;
    logic bouncy_out;
    logic busy;
    logic done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic bo;
        logic bsy;
        logic dn;
        int   t;
    } exp_t;

    exp_t sb[$];

    logic [15:0] m_lfsr;

    bounce_emulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clean_in   (clean_in),
        .enable     (enable),
        .rand_en    (rand_en),
        .bouncy_out (bouncy_out),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference Galois LFSR (taps 0xB400), steps while enable is high.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            m_lfsr <= 16'hACE1;
        else if (enable)
            m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Expected per-edge trace of one event, t = edges after E0.
    task automatic push_event(input logic nv, input int k, input int gap,
                              input int n);
        int len;
        int tg;
        exp_t e;
        len = gap * (2 * k + 1) + 16;
        for (int t = 0; t <= len; t++) begin
            if (n >= 0 && t >= n) break;
            tg = t / gap;
            if (tg > 2 * k) tg = 2 * k;
            e.bo  = nv ^ tg[0];
            e.bsy = (t < len);
            e.dn  = (t == len);
            e.t   = t;
            sb.push_back(e);
        end
    endtask

    task automatic push_const(input logic bo, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.bo  = bo;
            e.bsy = 1'b0;
            e.dn  = 1'b0;
            e.t   = i;
            sb.push_back(e);
        end
    endtask

    task automatic drain_n(input string tag, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                chk({tag, " empty"}, 1'b1, 1'b0);
                return;
            end
            e = sb.pop_front();
            chk($sformatf("%s t=%0d bouncy_out", tag, e.t), bouncy_out, e.bo);
            chk($sformatf("%s t=%0d busy", tag, e.t), busy, e.bsy);
            chk($sformatf("%s t=%0d done", tag, e.t), done, e.dn);
        end
    endtask

    task automatic drain_all(input string tag);
        while (sb.size() > 0) drain_n(tag, 1);
    endtask

    initial begin
        int k;
        int gap;
        logic nv;

        rst_n    = 1'b0;
        clean_in = 1'b0;
        enable   = 1'b1;
        rand_en  = 1'b0;
        #1;
        chk("reset bouncy_out", bouncy_out, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Quiet input after reset.
        push_const(1'b0, 50);
        drain_all("idle");

        // Fixed 0->1 event.
        push_event(1'b1, 3, 4, -1);
        clean_in = 1'b1;
        drain_all("fixed_rise");
        push_const(1'b1, 5);
        drain_all("post_rise");

        // Fixed 1->0 event.
        push_event(1'b0, 3, 4, -1);
        clean_in = 1'b0;
        drain_all("fixed_fall");

        // Glitch on clean_in during the event is absorbed.
        push_event(1'b1, 3, 4, -1);
        clean_in = 1'b1;
        drain_n("glitch", 4);
        clean_in = 1'b0;
        drain_n("glitch", 4);
        clean_in = 1'b1;
        drain_all("glitch");
        push_const(1'b1, 5);
        drain_all("post_glitch");

        // Bypass back to 0, then abort an event with enable.
        enable   = 1'b0;
        clean_in = 1'b0;
        push_const(1'b0, 3);
        drain_all("bypass0");
        enable   = 1'b1;
        clean_in = 1'b1;
        push_event(1'b1, 3, 4, 11);
        drain_all("pre_abort");
        enable = 1'b0;
        push_const(1'b1, 5);
        drain_all("abort");
        clean_in = 1'b0;
        push_const(1'b0, 3);
        drain_all("bypass_step");

        // Random events, parameters from the LFSR model.
        enable  = 1'b1;
        rand_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            k   = int'(m_lfsr[7:4]);
            if (k > 3) k = 3;
            gap = 4 + int'(m_lfsr[2:0]);
            nv  = ~clean_in;
            push_event(nv, k, gap, -1);
            clean_in = nv;
            drain_all($sformatf("rand%0d", i));
        end

        // Reset asserted during SETTLE.
        rand_en = 1'b0;
        push_event(~clean_in, 3, 4, 30);
        clean_in = ~clean_in;
        drain_all("pre_reset");
        rst_n = 1'b0;
        #1;
        chk("async reset bouncy_out", bouncy_out, 1'b0);
        chk("async reset busy", busy, 1'b0);
        chk("async reset done", done, 1'b0);
        @(negedge clk);
        clean_in = 1'b1;
        rst_n    = 1'b1;
        push_event(1'b1, 3, 4, -1);
        drain_all("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
